// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: overflow trap, pending-write register, 32x32 regfile, debug reads
module alu_writeback #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instruction,
   input  logic [31:0] result,
   input  logic [2:0]  flags,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic [31:0] rd_data_a,
   output logic [31:0] rd_data_b,
   output logic        trap,
   output logic [31:0] trap_instr,
   input  logic        trap_clear,
   output logic [2:0]  last_flags,
   output logic [31:0] retired_count,
   output logic [15:0] trap_count
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] regs_d [NUM_REGS];
   logic        pend_valid_q, pend_valid_d;
   logic [4:0]  pend_dest_q, pend_dest_d;
   logic [31:0] pend_data_q, pend_data_d;
   logic [2:0]  pend_flags_q, pend_flags_d;
   logic [31:0] trap_instr_q, trap_instr_d;
   logic [2:0]  last_flags_q, last_flags_d;
   logic [31:0] retired_q, retired_d;
   logic [15:0] trap_count_q, trap_count_d;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  dest;
   logic        accept;
   logic        trapping_op;
   logic        take_trap;

   assign opcode      = instruction[31:26];
   assign funct       = instruction[5:0];
   // R-type writes rd, everything else writes rt
   assign dest        = (opcode == 6'h00) ? instruction[15:11] : instruction[20:16];
   // Only signed add, sub and addi honour the overflow flag
   assign trapping_op = ((opcode == 6'h00) && ((funct == 6'h20) || (funct == 6'h22)))
                        || (opcode == 6'h08);
   assign accept      = in_valid && (state_q == ST_RUN);
   assign take_trap   = accept && trapping_op && flags[0];

   assign in_ready      = (state_q == ST_RUN);
   assign trap          = (state_q == ST_TRAP);
   assign trap_instr    = trap_instr_q;
   assign last_flags    = last_flags_q;
   assign retired_count = retired_q;
   assign trap_count    = trap_count_q;

   // Next-state: retire the pending write, then capture this cycle's accept or trap
   always_comb begin
      state_d      = state_q;
      regs_d       = regs_q;
      pend_valid_d = 1'b0;
      pend_dest_d  = pend_dest_q;
      pend_data_d  = pend_data_q;
      pend_flags_d = pend_flags_q;
      trap_instr_d = trap_instr_q;
      last_flags_d = last_flags_q;
      retired_d    = retired_q;
      trap_count_d = trap_count_q;

      if (pend_valid_q) begin
         if (pend_dest_q != 5'd0) begin
            regs_d[pend_dest_q] = pend_data_q;
         end
         retired_d    = retired_q + 32'd1;
         last_flags_d = pend_flags_q;
      end

      case (state_q)
         ST_RUN: begin
            if (take_trap) begin
               state_d      = ST_TRAP;
               trap_instr_d = instruction;
               if (trap_count_q != 16'hFFFF) begin
                  trap_count_d = trap_count_q + 16'd1;
               end
            end else if (accept) begin
               pend_valid_d = 1'b1;
               pend_dest_d  = dest;
               pend_data_d  = result;
               pend_flags_d = flags;
            end
         end
         ST_TRAP: begin
            if (trap_clear) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State, register file and statistics; reset drops any pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_valid_q <= 1'b0;
         pend_dest_q  <= '0;
         pend_data_q  <= '0;
         pend_flags_q <= '0;
         trap_instr_q <= '0;
         last_flags_q <= '0;
         retired_q    <= '0;
         trap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         regs_q       <= regs_d;
         pend_valid_q <= pend_valid_d;
         pend_dest_q  <= pend_dest_d;
         pend_data_q  <= pend_data_d;
         pend_flags_q <= pend_flags_d;
         trap_instr_q <= trap_instr_d;
         last_flags_q <= last_flags_d;
         retired_q    <= retired_d;
         trap_count_q <= trap_count_d;
      end
   end

   // Debug read port A: zero register, then pending bypass, then regfile
   always_comb begin
      rd_data_a = '0;
      if (rd_addr_a != 5'd0) begin
         if (pend_valid_q && (rd_addr_a == pend_dest_q)) begin
            rd_data_a = pend_data_q;
         end else begin
            rd_data_a = regs_q[rd_addr_a];
         end
      end
   end

   // Debug read port B: same priority as port A
   always_comb begin
      rd_data_b = '0;
      if (rd_addr_b != 5'd0) begin
         if (pend_valid_q && (rd_addr_b == pend_dest_q)) begin
            rd_data_b = pend_data_q;
         end else begin
            rd_data_b = regs_q[rd_addr_b];
         end
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic [31:0] result = '0;
   logic [2:0]  flags = '0;
   logic [4:0]  rd_addr_a = '0;
   logic [4:0]  rd_addr_b = '0;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        trap;
   logic [31:0] trap_instr;
   logic        trap_clear = 1'b0;
   logic [2:0]  last_flags;
   logic [31:0] retired_count;
   logic [15:0] trap_count;

   int checks = 0;
   int errors = 0;

   alu_writeback #(.NUM_REGS(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .result(result), .flags(flags),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .trap(trap), .trap_instr(trap_instr), .trap_clear(trap_clear),
      .last_flags(last_flags), .retired_count(retired_count), .trap_count(trap_count)
   );

   always #5 clk = ~clk;

   // Architectural reference: latest accepted value per register, queue of not-yet-retired flags
   logic [31:0] m_regs [32];
   logic [2:0]  m_pend [$];
   logic        m_trap;
   logic [31:0] m_tinstr;
   logic [31:0] m_ret;
   logic [15:0] m_tc;
   logic [2:0]  m_lf;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic bit is_signed_arith(input logic [31:0] ins);
      bit is_add, is_sub, is_addi;
      is_add  = (ins[31:26] == 6'd0) && (ins[5:0] == 6'h20);
      is_sub  = (ins[31:26] == 6'd0) && (ins[5:0] == 6'h22);
      is_addi = (ins[31:26] == 6'h08);
      return is_add || is_sub || is_addi;
   endfunction

   function automatic int dest_of(input logic [31:0] ins);
      if (ins[31:26] == 6'd0) return int'(ins[15:11]);
      return int'(ins[20:16]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend.delete();
      m_trap = 1'b0; m_tinstr = '0; m_ret = '0; m_tc = '0; m_lf = '0;
   endtask

   task automatic model_edge();
      if (m_pend.size() > 0) begin
         m_lf  = m_pend.pop_front();
         m_ret = m_ret + 1;
      end
      if (m_trap) begin
         if (trap_clear) m_trap = 1'b0;
      end else if (in_valid) begin
         if (is_signed_arith(instruction) && flags[0]) begin
            m_trap   = 1'b1;
            m_tinstr = instruction;
            if (m_tc != 16'hFFFF) m_tc = m_tc + 1;
         end else begin
            if (dest_of(instruction) != 0) m_regs[dest_of(instruction)] = result;
            m_pend.push_back(flags);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " rd_data_a"}, rd_data_a, (rd_addr_a == 0) ? 32'h0 : m_regs[rd_addr_a]);
      chk({tag, " rd_data_b"}, rd_data_b, (rd_addr_b == 0) ? 32'h0 : m_regs[rd_addr_b]);
      chk({tag, " trap"}, {31'b0, trap}, {31'b0, m_trap});
      chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, ~m_trap});
      chk({tag, " trap_instr"}, trap_instr, m_tinstr);
      chk({tag, " retired"}, retired_count, m_ret);
      chk({tag, " trap_count"}, {16'b0, trap_count}, {16'b0, m_tc});
      chk({tag, " last_flags"}, {29'b0, last_flags}, {29'b0, m_lf});
   endtask

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] res;
      logic [2:0]  flg;
      logic        clr;
      logic [4:0]  ra;
      logic [31:0] exp_ra;
      logic        exp_trap;
      logic [31:0] exp_ret;
      logic [15:0] exp_tc;
      logic [2:0]  exp_lf;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic [31:0] i_addu3, i_addiu4, i_addu4, i_addu0, i_add5, i_addu5, i_addu7, i_sub8, i_addiu6;
      i_addu3  = rtype(5'd1, 5'd2, 5'd3, 6'h21);
      i_addiu4 = itype(6'h09, 5'd1, 5'd4, 16'h0011);
      i_addu4  = rtype(5'd1, 5'd2, 5'd4, 6'h21);
      i_addu0  = rtype(5'd1, 5'd2, 5'd0, 6'h21);
      i_add5   = rtype(5'd1, 5'd2, 5'd5, 6'h20);
      i_addu5  = rtype(5'd1, 5'd2, 5'd5, 6'h21);
      i_addu7  = rtype(5'd1, 5'd2, 5'd7, 6'h21);
      i_sub8   = rtype(5'd1, 5'd2, 5'd8, 6'h22);
      i_addiu6 = itype(6'h09, 5'd0, 5'd6, 16'hABCD);

      vecs[0]  = '{1'b0, 32'h0,    32'h0,         3'b000, 1'b0, 5'd5, 32'h0,  1'b0, 32'd0, 16'd0, 3'b000};
      vecs[1]  = '{1'b1, i_addu3,  32'h7,         3'b000, 1'b0, 5'd3, 32'h7,  1'b0, 32'd0, 16'd0, 3'b000};
      vecs[2]  = '{1'b0, 32'h0,    32'h0,         3'b000, 1'b0, 5'd3, 32'h7,  1'b0, 32'd1, 16'd0, 3'b000};
      vecs[3]  = '{1'b1, i_addiu4, 32'h11,        3'b000, 1'b0, 5'd4, 32'h11, 1'b0, 32'd1, 16'd0, 3'b000};
      vecs[4]  = '{1'b1, i_addu4,  32'h22,        3'b000, 1'b0, 5'd4, 32'h22, 1'b0, 32'd2, 16'd0, 3'b000};
      vecs[5]  = '{1'b0, 32'h0,    32'h0,         3'b000, 1'b0, 5'd4, 32'h22, 1'b0, 32'd3, 16'd0, 3'b000};
      vecs[6]  = '{1'b1, i_addu0,  32'h55,        3'b001, 1'b0, 5'd0, 32'h0,  1'b0, 32'd3, 16'd0, 3'b000};
      vecs[7]  = '{1'b0, 32'h0,    32'h0,         3'b000, 1'b0, 5'd0, 32'h0,  1'b0, 32'd4, 16'd0, 3'b001};
      vecs[8]  = '{1'b1, i_add5,   32'h8000_0000, 3'b001, 1'b0, 5'd5, 32'h0,  1'b1, 32'd4, 16'd1, 3'b001};
      vecs[9]  = '{1'b1, i_addu5,  32'h9,         3'b000, 1'b0, 5'd5, 32'h0,  1'b1, 32'd4, 16'd1, 3'b001};
      vecs[10] = '{1'b1, i_addu5,  32'h9,         3'b000, 1'b1, 5'd5, 32'h0,  1'b0, 32'd4, 16'd1, 3'b001};
      vecs[11] = '{1'b1, i_addu5,  32'h9,         3'b000, 1'b0, 5'd5, 32'h9,  1'b0, 32'd4, 16'd1, 3'b001};
      vecs[12] = '{1'b0, 32'h0,    32'h0,         3'b000, 1'b0, 5'd5, 32'h9,  1'b0, 32'd5, 16'd1, 3'b000};

      #2;
      do_reset();
      rd_addr_a = 5'd5;
      rd_addr_b = 5'd31;
      #1;
      chk("reset in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset trap", {31'b0, trap}, 32'd0);
      chk("reset trap_instr", trap_instr, 32'd0);
      chk("reset last_flags", {29'b0, last_flags}, 32'd0);
      chk("reset retired", retired_count, 32'd0);
      chk("reset trap_count", {16'b0, trap_count}, 32'd0);
      chk("reset rd_data_a", rd_data_a, 32'd0);
      chk("reset rd_data_b", rd_data_b, 32'd0);

      // Directed table
      for (int v = 0; v < 13; v++) begin
         in_valid    = vecs[v].valid;
         instruction = vecs[v].instr;
         result      = vecs[v].res;
         flags       = vecs[v].flg;
         trap_clear  = vecs[v].clr;
         rd_addr_a   = vecs[v].ra;
         tick();
         chk($sformatf("vec%0d rd_data_a", v), rd_data_a, vecs[v].exp_ra);
         chk($sformatf("vec%0d trap", v), {31'b0, trap}, {31'b0, vecs[v].exp_trap});
         chk($sformatf("vec%0d in_ready", v), {31'b0, in_ready}, {31'b0, ~vecs[v].exp_trap});
         chk($sformatf("vec%0d retired", v), retired_count, vecs[v].exp_ret);
         chk($sformatf("vec%0d trap_count", v), {16'b0, trap_count}, {16'b0, vecs[v].exp_tc});
         chk($sformatf("vec%0d last_flags", v), {29'b0, last_flags}, {29'b0, vecs[v].exp_lf});
         if (v == 8) chk("vec8 trap_instr", trap_instr, i_add5);
      end

      // Pending write in flight when a trap is taken still commits
      in_valid = 1'b1; instruction = i_addu7; result = 32'h77; flags = 3'b000; trap_clear = 1'b0;
      rd_addr_a = 5'd7; rd_addr_b = 5'd8;
      tick();
      chk("flight bypass r7", rd_data_a, 32'h77);
      instruction = i_sub8; result = 32'h1234; flags = 3'b001;
      tick();
      chk("flight trap", {31'b0, trap}, 32'd1);
      chk("flight retired", retired_count, 32'd6);
      chk("flight r7", rd_data_a, 32'h77);
      chk("flight r8", rd_data_b, 32'h0);
      chk("flight trap_instr", trap_instr, i_sub8);
      chk("flight trap_count", {16'b0, trap_count}, 32'd2);
      in_valid = 1'b0; trap_clear = 1'b1;
      tick();
      trap_clear = 1'b0;
      chk("flight cleared", {31'b0, in_ready}, 32'd1);
      chk("flight retired hold", retired_count, 32'd6);

      // Randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         int kind;
         logic [4:0] r1, r2, r3;
         kind = int'($urandom_range(0, 7));
         r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
         case (kind)
            0: instruction = rtype(r1, r2, r3, 6'h21);
            1: instruction = rtype(r1, r2, r3, 6'h20);
            2: instruction = rtype(r1, r2, r3, 6'h22);
            3: instruction = itype(6'h08, r1, r2, 16'($urandom));
            4: instruction = itype(6'h09, r1, r2, 16'($urandom));
            5: instruction = rtype(r1, r2, r3, 6'h24);
            default: instruction = $urandom;
         endcase
         in_valid   = ($urandom_range(0, 3) != 0);
         result     = $urandom;
         flags      = 3'($urandom);
         trap_clear = ($urandom_range(0, 3) == 0);
         rd_addr_a  = 5'($urandom);
         rd_addr_b  = (c % 3 == 0) ? r3 : 5'($urandom);
         tick();
         check_model($sformatf("rand%0d", c));
      end

      // Asynchronous reset right after an accept drops the pending write
      do_reset();
      in_valid = 1'b1; instruction = i_addiu6; result = 32'hABCD; flags = 3'b000; trap_clear = 1'b0;
      rd_addr_a = 5'd6;
      tick();
      chk("mid bypass r6", rd_data_a, 32'hABCD);
      in_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid reset r6", rd_data_a, 32'h0);
      chk("mid reset retired", retired_count, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("mid after r6", rd_data_a, 32'h0);
      chk("mid after retired", retired_count, 32'd0);
      chk("mid after in_ready", {31'b0, in_ready}, 32'd1);
      chk("mid after trap", {31'b0, trap}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the single-cycle ALU. It accepts one ALU result per handshake, decodes the destination register from the instruction, and commits the result to a 32×32-bit register file with register 0 hardwired to zero. It traps on signed overflow from add/sub/addi, exposes two combinational debug read ports with bypass, and keeps retire/trap statistics.

## Interface
- NUM_REGS, 32: register file depth; fixed at 32, index width 5.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents instruction/result/flags.
- in_ready  output  1  stage can accept this cycle.
- instruction  input  32  instruction the ALU executed.
- result  input  32  ALU result.
- flags  input  3  ALU flags: [2] zero, [1] negative, [0] overflow.
- rd_addr_a / rd_addr_b  input  5  debug read addresses.
- rd_data_a / rd_data_b  output  32  debug read data, combinational.
- trap  output  1  high while in TRAP state.
- trap_instr  output  32  instruction that caused the trap.
- trap_clear  input  1  single-cycle pulse that leaves TRAP.
- last_flags  output  3  flags of the most recently committed instruction.
- retired_count  output  32  committed instructions, wraps at 2^32.
- trap_count  output  16  traps taken, saturates at 16'hFFFF.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready. in_ready = (state == RUN).
- Destination: opcode 0 (R-type) uses instruction[15:11] (rd). Any other opcode uses instruction[20:16] (rt).
- Trapping ops: R-type funct 6'h20 (add), R-type funct 6'h22 (sub), and opcode 6'h08 (addi). All other ops ignore flags[0].
- Accept with trapping op and flags[0]=1:
  - no commit;
  - state becomes TRAP;
  - trap_instr captures instruction;
  - trap_count increments (saturating).
  - retired_count and last_flags are unchanged.
- Any other accept loads the pending register (pend_valid=1, pend_dest, pend_data=result, pend_flags=flags).
- Pending register: at the next edge, pend_data is written to regfile[pend_dest], unless pend_dest==0. On that same edge retired_count increments and last_flags = pend_flags. A dest-0 write still counts as retired.
- The pending register and a new accept are processed on the same edge, giving back-to-back throughput of 1 per cycle.
- Read ports:
  - address 0 returns 0;
  - else, if pend_valid and address==pend_dest, return pend_data (bypass);
  - else return regfile[address].
- FSM with two states:
  - RUN: goes to TRAP on a trapping overflow accept.
  - TRAP: in_ready=0 and trap=1. Goes to RUN on an edge with trap_clear=1. trap_clear in RUN is ignored.
  - An in-flight pending write still commits normally on the edge after the trap is taken.
- Reset clears to 0: state=RUN, regfile, pend_valid, trap_instr, last_flags, retired_count, trap_count.

## Timing
- Reset values: in_ready=1, trap=0, trap_instr=0, last_flags=0, retired_count=0, trap_count=0, rd_data_*=0.
- Accept at edge N leads to:
  - bypass-visible on rd_data from N+ (after edge N);
  - regfile committed and counters updated at edge N+1.
- Trap at edge N: trap=1 and in_ready=0 from after edge N. trap_clear sampled high at edge M gives in_ready=1 after edge M. The earliest new accept is at edge M+1.
- Simultaneous accept to register X and pending commit to X: the older value writes at this edge, and the new value is pending and bypassed. Reads see the newer value.
- Async reset mid-operation drops any pending write; no partial commit.
- retired_count wraps 32'hFFFF_FFFF → 0. trap_count holds at 16'hFFFF.

## Test plan
- Reset then idle: all outputs zero, in_ready=1; rd_addr_a=5 gives rd_data_a=0.
- Accept addu (rs=1, rt=2, rd=3), result=32'h0000_0007:
  - rd_data_a(3)=7 the cycle after accept, via bypass;
  - retired_count=1 after the next edge.
- Back-to-back: addiu rt=4 with 32'h11, then addu rd=4 with 32'h22 on consecutive cycles. Reads return 32'h11 then 32'h22; final regfile[4]=32'h22; retired_count=2.
- add with flags=3'b001, rd=5, result=32'h8000_0000:
  - trap=1, trap_instr=instruction, trap_count=1, in_ready=0;
  - regfile[5] stays 0, retired_count unchanged;
  - in_valid held high is not accepted until trap_clear, then accepted one cycle later.
- addu with flags[0]=1: no trap, commits normally, last_flags=3'b001. A write to rd=0 reads back 0 but increments retired_count.
- Assert rst_n low the cycle after accepting addiu rt=6 = 32'hABCD: regfile[6]=0, retired_count=0, state RUN.
